// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state type and frame helper
// for the buffered UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int frame_bits(input int data_bits,
                                      input int parity,
                                      input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO with
// registered occupancy count and synchronous reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO refuses writes even when a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB first, with
// configurable width, parity, stop bits and baud divisor.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          TX_DATA,
    input  logic                          TX_EN,
    output logic                          TX_READY,
    output logic                          TX_OVF,
    output logic                          TX_BUSY,
    output logic                          TX_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          UART_TX
);

    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = $clog2(MAXB + 1);

    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_INV   = (PARITY == PARITY_ODD);
    localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 pop;
    logic                 full, empty;
    logic [DATA_BITS-1:0] rdata;
    logic                 tick;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (reset),
        .push_i  (TX_EN),
        .wdata_i (TX_DATA),
        .pop_i   (pop),
        .rdata_o (rdata),
        .count_o (FIFO_COUNT),
        .full_o  (full),
        .empty_o (empty)
    );

    assign tick     = (cnt_q == LAST_CNT);
    assign TX_READY = !full;
    assign TX_OVF   = TX_EN && full;
    assign TX_BUSY  = (state_q != ST_IDLE) || !empty;
    assign TX_DONE  = (state_q == ST_STOP) && tick && (bit_q == LAST_STOP);
    assign UART_TX  = tx_q;

    // Frame sequencing; tx_d is the line level for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rdata;
                    par_d   = (^rdata) ^ ODD_INV;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_q != LAST_STOP) begin
                        bit_d = bit_q + 1'b1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = rdata;
                        par_d   = (^rdata) ^ ODD_INV;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FSM, baud/bit counters and the registered serial output.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter configurations (8N1, 7O2, 8E1)
// decoded by serial-line monitors against a frame scoreboard.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] en     = '0;
    logic [7:0] d0     = '0;
    logic [6:0] d1     = '0;
    logic [7:0] d2     = '0;

    logic [2:0] txl, rdy, ovf, bsy, dn;
    logic [2:0] cnt0, cnt1, cnt2;

    int total = 0;
    int bad   = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] q2[$];
    bit          mon_busy[3];
    int          frames_seen[3];

    always #5 sysclk = ~sysclk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .sysclk(sysclk), .reset(reset), .TX_DATA(d0), .TX_EN(en[0]),
        .TX_READY(rdy[0]), .TX_OVF(ovf[0]), .TX_BUSY(bsy[0]),
        .TX_DONE(dn[0]), .FIFO_COUNT(cnt0), .UART_TX(txl[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .sysclk(sysclk), .reset(reset), .TX_DATA(d1), .TX_EN(en[1]),
        .TX_READY(rdy[1]), .TX_OVF(ovf[1]), .TX_BUSY(bsy[1]),
        .TX_DONE(dn[1]), .FIFO_COUNT(cnt1), .UART_TX(txl[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .sysclk(sysclk), .reset(reset), .TX_DATA(d2), .TX_EN(en[2]),
        .TX_READY(rdy[2]), .TX_OVF(ovf[2]), .TX_BUSY(bsy[2]),
        .TX_DONE(dn[2]), .FIFO_COUNT(cnt2), .UART_TX(txl[2]));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void qpush(input int k, input logic [11:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [11:0] qpop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic monitor(input int k, input int nb);
        logic [11:0] got;
        logic [11:0] exp;
        bit          ab;
        forever begin
            @(negedge sysclk);
            if (reset || txl[k]) continue;
            mon_busy[k] = 1'b1;
            got = '0;
            ab  = 1'b0;
            for (int c = 0; c < nb * CPB; c++) begin
                if (c > 0) @(negedge sysclk);
                if (reset) begin
                    ab = 1'b1;
                    break;
                end
                if (c % CPB == CPB / 2) got[c / CPB] = txl[k];
            end
            mon_busy[k] = 1'b0;
            if (ab) continue;
            frames_seen[k]++;
            if (qsize(k) == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame%0d: got=%h required=none", k, got);
            end else begin
                exp = qpop(k);
                chk($sformatf("frame%0d", k), int'(got), int'(exp));
            end
        end
    endtask

    initial monitor(0, frame_bits(8, PARITY_NONE, 1));
    initial monitor(1, frame_bits(7, PARITY_ODD, 2));
    initial monitor(2, frame_bits(8, PARITY_EVEN, 1));

    task automatic drive(input int k, input logic [7:0] v);
        en    = '0;
        en[k] = 1'b1;
        case (k)
            0: d0 = v;
            1: d1 = v[6:0];
            default: d2 = v;
        endcase
    endtask

    task automatic wait_idle(input int k, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge sysclk);
            if (qsize(k) == 0 && !mon_busy[k] && !bsy[k]) return;
        end
        chk($sformatf("drain_timeout%0d", k), 1, 0);
    endtask

    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [11:0] f;
        int          lat;
    } vec_t;

    vec_t vt[7];

    initial begin
        int ecnt[4];
        int dt[$];
        int lat;
        int snap;
        bit seen;

        vt[0] = '{0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 41};
        vt[1] = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 41};
        vt[2] = '{1, 8'h55, {1'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 45};
        vt[3] = '{1, 8'h01, {1'b0, 2'b11, 1'b0, 7'h01, 1'b0}, 45};
        vt[4] = '{2, 8'hFF, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 45};
        vt[5] = '{2, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 45};
        vt[6] = '{2, 8'h96, {1'b0, 1'b1, 1'b0, 8'h96, 1'b0}, 45};

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_tx", txl[0], 1);
        chk("rst_ready", rdy[0], 1);
        chk("rst_ovf", ovf[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_count", cnt0, 0);
        chk("rst_tx_7o2", txl[1], 1);
        @(posedge sysclk);
        #1 reset = 1'b0;

        // single byte A5: start at W+2, done at W+41, idle at W+42
        repeat (5) @(posedge sysclk);
        #1 drive(0, 8'hA5);
        qpush(0, {2'b00, 1'b1, 8'hA5, 1'b0});
        @(posedge sysclk);
        #1 en = '0;
        @(negedge sysclk);
        chk("a5_count_n1", cnt0, 1);
        chk("a5_busy_n1", bsy[0], 1);
        chk("a5_tx_n1", txl[0], 1);
        @(negedge sysclk);
        chk("a5_tx_start", txl[0], 0);
        repeat (38) @(posedge sysclk);
        @(negedge sysclk);
        chk("a5_done_early", dn[0], 0);
        @(negedge sysclk);
        chk("a5_done", dn[0], 1);
        @(negedge sysclk);
        chk("a5_done_after", dn[0], 0);
        chk("a5_busy_after", bsy[0], 0);
        wait_idle(0, 100);

        // four back-to-back writes: counts 1,1,2,3 then 4 contiguous frames
        ecnt = '{1, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            @(posedge sysclk);
            #1 drive(0, 8'(i + 1));
            qpush(0, {2'b00, 1'b1, 8'(i + 1), 1'b0});
            @(negedge sysclk);
            if (i > 0) chk($sformatf("b2b_count%0d", i - 1), cnt0, ecnt[i - 1]);
        end
        @(posedge sysclk);
        #1 en = '0;
        @(negedge sysclk);
        chk("b2b_count3", cnt0, ecnt[3]);
        dt.delete();
        for (int t = 5; t < 300; t++) begin
            @(negedge sysclk);
            if (dn[0]) dt.push_back(t);
        end
        chk("b2b_done_pulses", dt.size(), 4);
        if (dt.size() == 4) begin
            chk("b2b_done_first", dt[0], 41);
            for (int i = 1; i < 4; i++)
                chk($sformatf("b2b_done_gap%0d", i), dt[i] - dt[i - 1], 40);
        end
        wait_idle(0, 100);

        // overflow: sixth write rejected while full
        for (int i = 0; i < 6; i++) begin
            @(posedge sysclk);
            #1 drive(0, 8'(8'h10 + i));
            if (i < 5) qpush(0, {2'b00, 1'b1, 8'(8'h10 + i), 1'b0});
            @(negedge sysclk);
            chk($sformatf("ovf_ready%0d", i), rdy[0], (i < 5) ? 1 : 0);
            chk($sformatf("ovf_pulse%0d", i), ovf[0], (i < 5) ? 0 : 1);
        end
        @(posedge sysclk);
        #1 en = '0;
        @(negedge sysclk);
        chk("ovf_ready_hold", rdy[0], 0);
        chk("ovf_pulse_end", ovf[0], 0);
        chk("ovf_count", cnt0, 4);
        wait_idle(0, 400);

        // table of frame vectors across the three configurations
        foreach (vt[v]) begin
            @(posedge sysclk);
            #1 drive(vt[v].k, vt[v].d);
            qpush(vt[v].k, vt[v].f);
            @(posedge sysclk);
            #1 en = '0;
            lat  = 1;
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge sysclk);
                if (dn[vt[v].k]) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge sysclk);
                lat++;
            end
            chk($sformatf("vec%0d_done_lat", v), seen ? lat : -1, vt[v].lat);
            wait_idle(vt[v].k, 100);
        end

        // reset during data bit 3 of frame 1 with two words queued
        for (int i = 0; i < 3; i++) begin
            @(posedge sysclk);
            #1 drive(0, 8'(8'h11 * (i + 1)));
        end
        @(posedge sysclk);
        #1 en = '0;
        repeat (16) @(posedge sysclk);
        #1 reset = 1'b1;
        @(negedge sysclk);
        chk("mid_tx_bit3", txl[0], 0);
        chk("mid_count", cnt0, 2);
        @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);
        chk("mid_tx_after", txl[0], 1);
        chk("mid_count_after", cnt0, 0);
        chk("mid_busy_after", bsy[0], 0);
        chk("mid_ready_after", rdy[0], 1);
        snap = frames_seen[0];
        repeat (100) @(negedge sysclk);
        chk("mid_no_frames", frames_seen[0], snap);
        chk("mid_idle_line", txl[0], 1);
        @(posedge sysclk);
        #1 drive(0, 8'h5A);
        qpush(0, {2'b00, 1'b1, 8'h5A, 1'b0});
        @(posedge sysclk);
        #1 en = '0;
        wait_idle(0, 100);
        chk("post_rst_frames", frames_seen[0], snap + 1);

        chk("q0_empty", qsize(0), 0);
        chk("q1_empty", qsize(1), 0);
        chk("q2_empty", qsize(2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, successor to the single-byte sender. Accepts words from the CPU/peripheral bus side at up to one per cycle, buffers them, and serialises them LSB-first on UART_TX with configurable data width, parity, stop bits and baud divisor. Back-to-back frames go out with no idle gap while the FIFO holds data.

## Interface
Parameters:
- CLKS_PER_BIT, 5208: sysclk cycles per bit period; legal ≥ 2.
- DATA_BITS, 8: data bits per frame; legal 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries; power of two, ≥ 2.

Ports:
- sysclk  in  1  clock; one clock domain. Reset is synchronous, active-high.
- reset  in  1  synchronous active-high reset.
- TX_DATA  in  DATA_BITS  word to send.
- TX_EN  in  1  write strobe. Accepted when TX_READY=1.
- TX_READY  out  1  FIFO not full, registered.
- TX_OVF  out  1  one-cycle pulse: TX_EN while TX_READY=0. The word is dropped.
- TX_BUSY  out  1  FSM not IDLE or FIFO non-empty.
- TX_DONE  out  1  one-cycle pulse at the end of each frame's last stop bit.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- UART_TX  out  1  serial line. Idle high.

## Operation
- Reset values: UART_TX=1, TX_READY=1, TX_OVF=0, TX_BUSY=0, TX_DONE=0, FIFO_COUNT=0. FSM goes to IDLE and the FIFO is flushed.
- Reset mid-frame aborts the frame. UART_TX is 1 on the cycle after reset is sampled. Buffered words are discarded.
- Write: push on TX_EN && TX_READY. TX_READY is derived from the registered count.
  - A write while full is rejected, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves FIFO_COUNT unchanged.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE/START.
  - IDLE: if FIFO non-empty, pop into shift register and go to START.
  - START: drive 0 for one bit period.
  - DATA: drive shift[0] and shift right each bit period, for DATA_BITS periods.
  - PARITY: present only if PARITY≠0. Drive XOR of the data bits for even parity, its inverse for odd.
  - STOP: drive 1 for STOP_BITS periods. At the end of the last period, pulse TX_DONE.
    - If the FIFO is non-empty, pop and go directly to START (no idle cycle).
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 within every non-IDLE state and wraps at CLKS_PER_BIT-1. Each bit therefore lasts exactly CLKS_PER_BIT cycles. The counter is held at 0 in IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- The bit counter must be wide enough for max(DATA_BITS, STOP_BITS).

## Timing
- Write at cycle N into an empty FIFO with the FSM in IDLE:
  - FIFO_COUNT=1 and TX_BUSY=1 at N+1.
  - Pop at N+1; UART_TX falls at N+2.
  - Write-to-start-bit latency is 2 cycles.
- UART_TX is registered, with no combinational path from any input.
- TX_DONE is asserted on the last cycle of the last stop bit.
  - With queued data, the start bit of the next frame appears on the following cycle.
- TX_BUSY deasserts on the cycle after TX_DONE when the FIFO is empty.
- TX_READY falls the cycle after the write that fills the FIFO. It rises the cycle after a pop from full.

## Structure
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants.
  - The tx state enum (IDLE, START, DATA, PARITY, STOP).
  - A frame_bits() function used by the bench.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Registered count, synchronous active-high reset.
  - Read data is valid in the same cycle as the pop (first-word fall-through).

## Test plan
Bench parameters are CLKS_PER_BIT=4 unless stated otherwise.
- Single byte 8'hA5, 8N1: 0x105 TX_EN at cycle 10 → UART_TX low at cycle 12, then bits 1,0,1,0,0,1,0,1, then stop. Each bit is 4 cycles. TX_DONE pulses at cycle 51. TX_BUSY is 0 at cycle 52.
- Four writes 8'h01..8'h04 on consecutive cycles, FIFO_DEPTH=4, CLKS_PER_BIT=4:
  - FIFO_COUNT sequence is 1,1,2,3 (the first pop overlaps).
  - Four contiguous 40-cycle frames follow with no idle gap.
  - TX_DONE pulses 4 times, 40 cycles apart.
- Overflow: 6 writes back-to-back with FIFO_DEPTH=4, slow baud → TX_READY=0 once full. TX_OVF pulses for the rejected write. The dropped word never appears on UART_TX.
- Parity/width: DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2, data 7'h55 → frame of 0, 1010101, parity 1, 1, 1. Total 11 bits = 44 cycles.
- Even parity, data 8'hFF → parity bit 0. Data 8'h01 → parity bit 1.
- Reset mid-frame: assert reset during data bit 3 of frame 1, with 2 words queued → UART_TX=1 next cycle. FIFO_COUNT=0, TX_BUSY=0. No further frames are sent. The next write after reset transmits normally.
